// File: rtl/bsg_chip_noc_flit_deserializer.sv
// Reassembles narrow tunnel flits into one wide manycore packet, flit 0 least significant.
// The output register is a one-entry buffer, so the final flit can refill it in the same cycle it is dequeued.
module bsg_chip_noc_flit_deserializer #(
    parameter int wide_width_p = 0,
    parameter int flit_width_p = 0,
    localparam int wide_lp      = (wide_width_p < 1) ? 1 : wide_width_p,
    localparam int flit_lp      = (flit_width_p < 1) ? 1 : flit_width_p,
    localparam int num_flits_lp = (wide_lp + flit_lp - 1) / flit_lp,
    localparam int cnt_width_lp = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [flit_lp-1:0] data_i,
    output logic               ready_and_o,
    output logic               v_o,
    output logic [wide_lp-1:0] data_o,
    input  logic               yumi_i,
    output logic               partial_o
);

    localparam int full_w_lp = num_flits_lp * flit_lp;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(num_flits_lp - 1);

    logic [cnt_width_lp-1:0] r_cnt;
    logic                    r_out_v;
    logic [wide_lp-1:0]      r_data;

    logic                    w_last;
    logic                    w_accept;
    logic [full_w_lp-1:0]    w_full;

    assign w_last = (r_cnt == last_cnt_lp);

    // Reset is folded in so the link sees no ready while the block is held in reset.
    assign ready_and_o = reset_n_i & ~(w_last & r_out_v & ~yumi_i);
    assign w_accept    = v_i & ready_and_o;

    assign v_o       = r_out_v;
    assign data_o    = r_data;
    assign partial_o = (r_cnt != '0);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt   <= '0;
            r_out_v <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + cnt_width_lp'(1);
            end
            if (w_accept && w_last) begin
                r_out_v <= 1'b1;
            end else if (yumi_i) begin
                r_out_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept && w_last) begin
            r_data <= w_full[wide_lp-1:0];
        end
    end

    if (num_flits_lp > 1) begin : g_multi
        for (genvar i = 0; i < num_flits_lp - 1; i++) begin : g_slot
            logic [flit_lp-1:0] r_slot;

            always_ff @(posedge clk_i) begin
                if (w_accept && (r_cnt == cnt_width_lp'(i))) begin
                    r_slot <= data_i;
                end
            end

            assign w_full[i*flit_lp +: flit_lp] = r_slot;
        end
        assign w_full[full_w_lp-1 -: flit_lp] = data_i;
    end else begin : g_single
        assign w_full = data_i;
    end

    // Padding bits of the final flit beyond the packet width are dropped on purpose.
    if (full_w_lp > wide_lp) begin : g_trunc
        logic w_unused_bits;
        assign w_unused_bits = ^w_full[full_w_lp-1:wide_lp];
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> r_out_v);

    a_params_set: assert property (@(posedge clk_i)
        (wide_width_p >= 1) && (flit_width_p >= 1));

endmodule

// File: tb/tb_bsg_chip_noc_flit_deserializer.sv
// Bench for the flit deserializer: 80/32 instance against a scoreboard model,
// plus single-flit (16/32) and exact-fit (64/32) instances with directed checks.
module tb_bsg_chip_noc_flit_deserializer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int npop = 0;
    int yumi_mode = 0;
    logic yumi_man = 1'b0;
    int last_acc = 0;

    logic        v0, rdy0, vo0, yumi0, part0;
    logic [31:0] d0;
    logic [79:0] do0;

    logic        v1, rdy1, vo1, yumi1, part1;
    logic [31:0] d1;
    logic [15:0] do1;

    logic        v2, rdy2, vo2, yumi2, part2;
    logic [31:0] d2;
    logic [63:0] do2;

    logic [31:0] pend[$];
    logic [79:0] sb[$];

    assign yumi1 = vo1;
    assign yumi2 = vo2;

    bsg_chip_noc_flit_deserializer #(.wide_width_p(80), .flit_width_p(32)) u0 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v0), .data_i(d0), .ready_and_o(rdy0),
        .v_o(vo0), .data_o(do0), .yumi_i(yumi0), .partial_o(part0));

    bsg_chip_noc_flit_deserializer #(.wide_width_p(16), .flit_width_p(32)) u1 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v1), .data_i(d1), .ready_and_o(rdy1),
        .v_o(vo1), .data_o(do1), .yumi_i(yumi1), .partial_o(part1));

    bsg_chip_noc_flit_deserializer #(.wide_width_p(64), .flit_width_p(32)) u2 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v2), .data_i(d2), .ready_and_o(rdy2),
        .v_o(vo2), .data_o(do2), .yumi_i(yumi2), .partial_o(part2));

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: collect three flits, packet = sum of flit_k * 2^(32k), keep low 80 bits.
    task automatic model_accept(input logic [31:0] d);
        logic [95:0] acc;
        pend.push_back(d);
        if (pend.size() == 3) begin
            acc = '0;
            for (int k = 0; k < 3; k++) begin
                acc = acc + (96'(pend[k]) << (32 * k));
            end
            sb.push_back(acc[79:0]);
            pend.delete();
        end
    endtask

    task automatic send0(input logic [31:0] d, output int stalls);
        bit done;
        stalls = 0;
        done = 1'b0;
        v0 = 1'b1;
        d0 = d;
        while (!done) begin
            @(negedge clk);
            if (rdy0) begin
                model_accept(d);
                last_acc = cyc;
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 40) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: flit %h stalled %0d cycles, want accept", d, stalls);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        v0 = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (yumi_mode)
            0:       yumi0 = yumi_man & vo0;
            1:       yumi0 = vo0;
            default: yumi0 = vo0 & ($urandom_range(0, 1) == 1);
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && vo0 && yumi0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pkt: got %h want none", do0);
            end else begin
                chk("pkt", do0, sb.pop_front());
                npop++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) chk("single_partial", part1, 0);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, ssum, first, np;
        logic [31:0] a, b0, b1, b2, r;
        logic [95:0] t;
        logic [79:0] exp_b, exp_c;

        rst_n = 1'b0;
        v0 = 1'b0; d0 = '0; yumi0 = 1'b0;
        v1 = 1'b0; d1 = '0;
        v2 = 1'b0; d2 = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", rdy0, 0);
        chk("rst_v", vo0, 0);
        chk("rst_partial", part0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", rdy0, 1);

        // Single-flit config: every flit is final, upper 16 bits dropped.
        v1 = 1'b1;
        d1 = 32'hDEAD_BEEF;
        #1;
        chk("single_ready", rdy1, 1);
        @(posedge clk);
        #1;
        chk("single_v", vo1, 1);
        chk("single_data", do1, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            d1 = r;
            @(posedge clk);
            #1;
            chk("single_rand", do1, 80'(r[15:0]));
        end
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("single_drain", vo1, 0);

        // Exact fit 64/32.
        v2 = 1'b1;
        d2 = 32'hFFFF_FFFF;
        #1;
        chk("fit_ready", rdy2, 1);
        @(posedge clk);
        #1;
        chk("fit_partial", part2, 1);
        d2 = 32'h0000_0001;
        @(posedge clk);
        #1;
        chk("fit_v", vo2, 1);
        chk("fit_data", do2, 64'h0000_0001_FFFF_FFFF);
        chk("fit_partial_clr", part2, 0);
        d2 = 32'h1234_5678;
        @(posedge clk);
        #1;
        d2 = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        chk("fit_data2", do2, 64'h9ABC_DEF0_1234_5678);

        // Basic assembly with yumi following v_o.
        yumi_mode = 1;
        send0(32'h1111_1111, s);
        chk("basic_partial1", part0, 1);
        send0(32'h2222_2222, s);
        chk("basic_partial2", part0, 1);
        send0(32'h0000_ABCD, s);
        chk("basic_v", vo0, 1);
        chk("basic_data", do0, 80'hABCD_2222_2222_1111_1111);
        chk("basic_partial3", part0, 0);
        repeat (3) begin @(posedge clk); #1; end

        // Back-pressure: held packet A blocks B's final flit until yumi.
        yumi_mode = 0;
        yumi_man = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            send0(a, s);
        end
        b0 = $urandom; b1 = $urandom; b2 = $urandom;
        t = {b2, b1, b0};
        exp_b = t[79:0];
        send0(b0, s);
        send0(b1, s);
        chk("bp_hold_v", vo0, 1);
        chk("bp_partial", part0, 1);
        v0 = 1'b1;
        d0 = b2;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stall_ready", rdy0, 0);
            @(posedge clk);
            #1;
        end
        yumi_man = 1'b1;
        @(negedge clk);
        chk("bp_ready_on_yumi", rdy0, 1);
        model_accept(b2);
        @(posedge clk);
        #1;
        v0 = 1'b0;
        chk("bp_v_kept", vo0, 1);
        chk("bp_data_b", do0, exp_b);
        @(posedge clk);
        #1;
        yumi_man = 1'b0;
        chk("bp_drained", vo0, 0);

        // Streaming: 9 flits back to back.
        yumi_mode = 1;
        np = npop;
        ssum = 0;
        first = 0;
        for (int i = 0; i < 9; i++) begin
            send0($urandom, s);
            ssum += s;
            if (i == 0) first = last_acc;
        end
        chk("stream_stalls", ssum, 0);
        chk("stream_span", last_acc - first, 8);
        repeat (3) begin @(posedge clk); #1; end
        chk("stream_pkts", npop - np, 3);

        // Reset with a held packet and a partial packet in flight.
        yumi_mode = 0;
        yumi_man = 1'b0;
        for (int i = 0; i < 4; i++) send0($urandom, s);
        chk("prerst_v", vo0, 1);
        chk("prerst_partial", part0, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_v", vo0, 0);
        chk("midrst_partial", part0, 0);
        chk("midrst_ready", rdy0, 0);
        pend.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        yumi_mode = 1;
        np = npop;
        b0 = $urandom; b1 = $urandom; b2 = $urandom;
        t = {b2, b1, b0};
        exp_c = t[79:0];
        send0(b0, s);
        send0(b1, s);
        send0(b2, s);
        chk("postrst_v", vo0, 1);
        chk("postrst_data", do0, exp_c);
        repeat (3) begin @(posedge clk); #1; end
        chk("postrst_pkts", npop - np, 1);

        // Random gaps and random yumi.
        yumi_mode = 2;
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send0($urandom, s);
        end
        yumi_mode = 1;
        repeat (6) begin @(posedge clk); #1; end
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_pend_empty", pend.size(), 0);
        chk("rand_v_idle", vo0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
